// File: rtl/traffic_light_monitor.sv
// Passive safety checker for the intersection light controller outputs.
// Latches a sticky fault with a cause code and counts completed signal cycles.
module traffic_light_monitor #(
   parameter int MIN_GREEN  = 11,
   parameter int MAX_GREEN  = 11,
   parameter int MIN_YELLOW = 4,
   parameter int MAX_YELLOW = 4,
   parameter int DW         = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  ns,
   input  logic [1:0]  ew,
   input  logic        clr,
   output logic        fault,
   output logic [2:0]  fault_code,
   output logic [15:0] cycles,
   output logic        synced
);

   localparam logic [1:0] GREEN  = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] RED    = 2'b10;
   localparam logic [1:0] BAD    = 2'b11;

   localparam logic [DW-1:0] MIN_G    = DW'(MIN_GREEN);
   localparam logic [DW-1:0] MAX_G    = DW'(MAX_GREEN);
   localparam logic [DW-1:0] MIN_Y    = DW'(MIN_YELLOW);
   localparam logic [DW-1:0] MAX_Y    = DW'(MAX_YELLOW);
   localparam logic [DW-1:0] DW_ONE   = DW'(1);
   localparam logic [DW-1:0] DW_SAT   = {DW{1'b1}};

   typedef enum logic [1:0] {S_CAPT, S_SYNC, S_RUN, S_FAULT} state_t;

   state_t        state;
   logic [1:0]    prev_ns;
   logic [1:0]    prev_ew;
   logic [DW-1:0] dwell;

   logic          changed;
   logic [1:0]    prev_phase;
   logic          conflict;
   logic          invalid;
   logic          bad_seq;
   logic          green_short;
   logic          green_long;
   logic          yellow_short;
   logic          yellow_long;
   logic [2:0]    sync_code;
   logic [2:0]    run_code;
   logic [DW-1:0] dwell_next;
   logic          cycle_done;

   // Only hold, G->Y, Y->R and R->G are legal per direction.
   function automatic logic step_ok(input logic [1:0] p, input logic [1:0] c);
      return (p == c) || (p == GREEN && c == YELLOW) ||
             (p == YELLOW && c == RED) || (p == RED && c == GREEN);
   endfunction

   // Phase of the previous sample: the non-red direction, or RED when all-red.
   always_comb begin
      changed      = (ns != prev_ns) || (ew != prev_ew);
      prev_phase   = (prev_ns != RED) ? prev_ns : prev_ew;
      conflict     = (ns != RED) && (ew != RED);
      invalid      = (ns == BAD) || (ew == BAD);
      bad_seq      = !step_ok(prev_ns, ns) || !step_ok(prev_ew, ew);
      green_short  = changed && (prev_phase == GREEN) && (dwell < MIN_G);
      green_long   = !changed && (prev_phase == GREEN) && (dwell >= MAX_G);
      yellow_short = changed && (prev_phase == YELLOW) && (dwell < MIN_Y);
      yellow_long  = !changed && (prev_phase == YELLOW) && (dwell >= MAX_Y);
      cycle_done   = (prev_ew == YELLOW) && (ew == RED);

      sync_code = 3'd0;
      if (conflict)     sync_code = 3'd1;
      else if (invalid) sync_code = 3'd2;

      run_code = 3'd0;
      if (conflict)          run_code = 3'd1;
      else if (invalid)      run_code = 3'd2;
      else if (bad_seq)      run_code = 3'd3;
      else if (green_short)  run_code = 3'd4;
      else if (green_long)   run_code = 3'd5;
      else if (yellow_short) run_code = 3'd6;
      else if (yellow_long)  run_code = 3'd7;

      if (changed)               dwell_next = DW_ONE;
      else if (dwell == DW_SAT)  dwell_next = dwell;
      else                       dwell_next = dwell + DW_ONE;
   end

   // clr takes priority over any violation seen on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_CAPT;
         prev_ns    <= RED;
         prev_ew    <= RED;
         dwell      <= '0;
         fault      <= 1'b0;
         fault_code <= 3'd0;
         cycles     <= 16'd0;
         synced     <= 1'b0;
      end else if (clr) begin
         state      <= S_SYNC;
         prev_ns    <= ns;
         prev_ew    <= ew;
         dwell      <= '0;
         fault      <= 1'b0;
         fault_code <= 3'd0;
         cycles     <= 16'd0;
         synced     <= 1'b0;
      end else begin
         case (state)
            S_CAPT: begin
               prev_ns <= ns;
               prev_ew <= ew;
               state   <= S_SYNC;
            end
            S_SYNC: begin
               prev_ns <= ns;
               prev_ew <= ew;
               dwell   <= dwell_next;
               if (sync_code != 3'd0) begin
                  state      <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= sync_code;
                  synced     <= 1'b0;
               end else if (changed) begin
                  state  <= S_RUN;
                  synced <= 1'b1;
               end
            end
            S_RUN: begin
               prev_ns <= ns;
               prev_ew <= ew;
               dwell   <= dwell_next;
               if (run_code != 3'd0) begin
                  state      <= S_FAULT;
                  fault      <= 1'b1;
                  fault_code <= run_code;
                  synced     <= 1'b0;
               end else if (cycle_done) begin
                  cycles <= cycles + 16'd1;
               end
            end
            S_FAULT: begin
               state <= S_FAULT;
            end
            default: begin
               state <= S_CAPT;
            end
         endcase
      end
   end

endmodule
